reset_seq_ctrl: RTL
===================

// Module: reset_seq_ctrl
//
// PURPOSE
//   Parametrised multi-domain reset sequencer. After async reset deassertion:
//     - hold all domains in reset for a minimum time
//     - gate clocks while the clock tree settles
//     - release NUM_DOM reset domains one after another, with a fixed stagger
//     - keep clocks gated until the reset tree has propagated, then ungate
//   Sits between the chip reset pad synchroniser and the per-domain reset/ICG cells.
//   Supports a software-requested re-sequence once the sequence has completed.
//
// PARAMETERS
//   NUM_DOM       4  number of reset domains (1..32)
//   MIN_RST_CYC   5  cycles all domains held in reset after deassertion (>=1)
//   CLK_TREE_CYC  7  cycles clocks gated before the first release (>=1)
//   STAGGER_CYC   2  cycles between consecutive domain releases (>=1)
//   RST_TREE_CYC  8  cycles clocks stay gated after the last release (>=1)
//
// PORTS
//   clk              in   1        clock
//   reset            in   1        reset, asynchronous, active-high
//   sw_rst_req_i     in   1        software re-sequence request (level, sampled in DONE)
//   dom_mask_i       in   NUM_DOM  1 = domain kept in reset (RESET_SEQ_DOMAIN_MASK_EN only)
//   gate_clk_o       out  1        1 = clocks gated
//   release_reset_o  out  NUM_DOM  bit i = 1: domain i out of reset
//   seq_done_o       out  1        1 = sequence complete, clocks running
//
// BEHAVIOUR
//   - Reset values (async): state HOLD, counter loaded; gate_clk_o=0, release_reset_o=0, seq_done_o=0.
//   - All outputs are registered or decoded from state only; no input reaches an output combinationally.
//   - Cycle 0 is the first clk cycle after reset deasserts.
//   - FSM states: HOLD -> GATE -> RELEASE -> TAIL -> DONE.
//     - HOLD:    MIN_RST_CYC cycles; gate_clk_o=0, release_reset_o=0.
//     - GATE:    CLK_TREE_CYC cycles; gate_clk_o=1.
//     - RELEASE: domains released in ascending index. The next domain's bit rises every STAGGER_CYC
//                cycles, starting at RELEASE entry. Released bits stay 1. gate_clk_o=1.
//     - TAIL:    entered on the cycle of the last release (T). gate_clk_o=1 through T+RST_TREE_CYC-1.
//     - DONE:    from T+RST_TREE_CYC; gate_clk_o=0, seq_done_o=1, release bits unchanged.
//   - Defaults:
//     - gate_clk_o rises at cycle 5.
//     - release bits rise at cycles 12, 14, 16, 18.
//     - gate_clk_o falls and seq_done_o rises at cycle 26.
//   - sw_rst_req_i=1 while in DONE: on the next cycle release_reset_o=0, seq_done_o=0, state HOLD.
//     That cycle counts as cycle 0 of a new sequence.
//   - sw_rst_req_i is ignored in every state other than DONE.
//   - Reset asserted mid-sequence clears all outputs immediately (asynchronously) and restarts from HOLD.
//   - Counter width: $clog2(max(MIN_RST_CYC, CLK_TREE_CYC, STAGGER_CYC, RST_TREE_CYC)+1).
//     The counter never wraps; it reloads on every state or domain step.
//   - Parameter values out of range: elaboration-time $error.
//
// CONFIGURATION
//   RESET_SEQ_DOMAIN_MASK_EN defined:
//     - dom_mask_i port present; sampled into a register on the GATE->RELEASE transition.
//     - Masked domains keep release_reset_o=0 until the next reset or re-sequence.
//     - Masked domains consume no stagger slot; unmasked domains are released contiguously
//       in ascending index.
//     - All domains masked: T = RELEASE entry cycle; TAIL follows directly.
//   RESET_SEQ_DOMAIN_MASK_EN undefined:
//     - dom_mask_i port absent; all domains are released as above.
//
// TESTING
//   1. Defaults, reset pulse then idle -> gate_clk_o 1 at cycles 5..25; release bits 0..3 rise at
//      12/14/16/18; seq_done_o=1 from cycle 26.
//   2. Reset reasserted at cycle 15 -> release_reset_o=0 and gate_clk_o=0 with no clock edge;
//      after deassertion the full sequence timing of test 1 repeats.
//   3. In DONE, sw_rst_req_i=1 for 1 cycle -> next cycle release_reset_o=4'b0000, seq_done_o=0;
//      test 1 timing repeats from that cycle.
//   4. sw_rst_req_i=1 during GATE and RELEASE -> no effect; timing identical to test 1.
//   5. MASK_EN, dom_mask_i=4'b0101 -> bit1 at 12, bit3 at 14, bits 0 and 2 stay 0;
//      gate_clk_o falls and seq_done_o rises at 22.
//   6. NUM_DOM=1, STAGGER_CYC=1 -> release_reset_o rises at 12; gate_clk_o falls and
//      seq_done_o rises at 20.

Source files
------------

// File: rtl/reset_seq_ctrl.sv
// Multi-domain reset sequencer: hold, clock-gate, staggered domain release, tail, done.
// Optional per-domain release mask enabled by defining RESET_SEQ_DOMAIN_MASK_EN.
module reset_seq_ctrl #(
   parameter int NUM_DOM      = 4,
   parameter int MIN_RST_CYC  = 5,
   parameter int CLK_TREE_CYC = 7,
   parameter int STAGGER_CYC  = 2,
   parameter int RST_TREE_CYC = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sw_rst_req_i,
`ifdef RESET_SEQ_DOMAIN_MASK_EN
   input  logic [NUM_DOM-1:0] dom_mask_i,
`endif
   output logic               gate_clk_o,
   output logic [NUM_DOM-1:0] release_reset_o,
   output logic               seq_done_o
);

   localparam int MAX_HG  = (MIN_RST_CYC > CLK_TREE_CYC) ? MIN_RST_CYC : CLK_TREE_CYC;
   localparam int MAX_ST  = (STAGGER_CYC > RST_TREE_CYC) ? STAGGER_CYC : RST_TREE_CYC;
   localparam int MAX_ALL = (MAX_HG > MAX_ST) ? MAX_HG : MAX_ST;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);

   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(MIN_RST_CYC - 1);
   localparam logic [CNT_W-1:0] GATE_LD = CNT_W'(CLK_TREE_CYC - 1);
   localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER_CYC - 1);
   localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(RST_TREE_CYC - 1);

   localparam logic [2:0] S_HOLD    = 3'd0;
   localparam logic [2:0] S_GATE    = 3'd1;
   localparam logic [2:0] S_RELEASE = 3'd2;
   localparam logic [2:0] S_TAIL    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   if (NUM_DOM < 1 || NUM_DOM > 32) begin : g_bad_num_dom
      $error("reset_seq_ctrl: NUM_DOM must be in 1..32");
   end
   if (MIN_RST_CYC < 1 || CLK_TREE_CYC < 1 || STAGGER_CYC < 1 || RST_TREE_CYC < 1) begin : g_bad_cyc
      $error("reset_seq_ctrl: all cycle parameters must be >= 1");
   end

   logic [2:0]         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [NUM_DOM-1:0] pend_reg, pend_next;
   logic [NUM_DOM-1:0] rel_reg, rel_next;
   logic               gate_reg, gate_next;
   logic               done_reg, done_next;

   logic [NUM_DOM-1:0] init_pend;
   logic [NUM_DOM-1:0] step_src;
   logic [NUM_DOM-1:0] step_low;
   logic [NUM_DOM-1:0] step_rem;

   // Domains still waiting for release; the mask is captured as this set on GATE exit.
`ifdef RESET_SEQ_DOMAIN_MASK_EN
   assign init_pend = ~dom_mask_i;
`else
   assign init_pend = '1;
`endif

   assign step_src = (state_reg == S_GATE) ? init_pend : pend_reg;
   assign step_low = step_src & ~(step_src - NUM_DOM'(1));
   assign step_rem = step_src & (step_src - NUM_DOM'(1));

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg;
      rel_next   = rel_reg;
      gate_next  = gate_reg;
      done_next  = done_reg;
      case (state_reg)
         S_HOLD: begin
            if (cnt_reg == '0) begin
               state_next = S_GATE;
               cnt_next   = GATE_LD;
               gate_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_GATE, S_RELEASE: begin
            if (cnt_reg == '0) begin
               // Release the lowest pending domain; the last one (or none) enters TAIL.
               rel_next  = rel_reg | step_low;
               pend_next = step_rem;
               if (step_rem == '0) begin
                  state_next = S_TAIL;
                  cnt_next   = TAIL_LD;
               end else begin
                  state_next = S_RELEASE;
                  cnt_next   = STAG_LD;
               end
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_TAIL: begin
            if (cnt_reg == '0) begin
               state_next = S_DONE;
               gate_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (sw_rst_req_i) begin
               state_next = S_HOLD;
               cnt_next   = HOLD_LD;
               pend_next  = '0;
               rel_next   = '0;
               gate_next  = 1'b0;
               done_next  = 1'b0;
            end
         end
         default: begin
            state_next = S_HOLD;
            cnt_next   = HOLD_LD;
            pend_next  = '0;
            rel_next   = '0;
            gate_next  = 1'b0;
            done_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_HOLD;
         cnt_reg   <= HOLD_LD;
         pend_reg  <= '0;
         rel_reg   <= '0;
         gate_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
         rel_reg   <= rel_next;
         gate_reg  <= gate_next;
         done_reg  <= done_next;
      end
   end

   assign gate_clk_o      = gate_reg;
   assign release_reset_o = rel_reg;
   assign seq_done_o      = done_reg;

endmodule
